// File: rtl/rcom_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// rcom_cmd_sequencer
//
// Queues a script of 16-bit Knight commands and hands them to RemoteComm
// one at a time: present cmd with a one-cycle snd_cmd strobe, wait for
// cmd_snt, then wait for the Knight's response byte. An ACK_VAL response
// retires the head entry. Any other response, or a stall in either wait
// state, drops into a sticky error state that flushes the queue.
//
// Optional build macro: RCOM_RETRY_EN
//   When defined, a NAK or a response timeout resends the same head entry,
//   up to 3 times per command. The error state is entered only on the 4th
//   consecutive failure. A cmd_snt timeout is never retried.
// ---------------------------------------------------------------------------
module rcom_cmd_sequencer #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_VAL        = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_cmd_i,
  input  logic [15:0]                wr_data_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  input  logic                       start_i,
  output logic [15:0]                cmd_o,
  output logic                       snd_cmd_o,
  input  logic                       cmd_snt_i,
  input  logic                       resp_rdy_i,
  input  logic [7:0]                 resp_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_NAK      = 2'b01;
  localparam logic [1:0] ERR_SNT_TMO  = 2'b10;
  localparam logic [1:0] ERR_RESP_TMO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_ERR
  } state_e;

  state_e          state_q, state_d;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, rd_ptr_pop;
  logic [CW-1:0]   count_q, count_d, count_upd;

  logic [15:0]     cmd_q, head_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

`ifdef RCOM_RETRY_EN
  logic [1:0]      retry_q, retry_d;
`endif

  logic            push_ok;
  logic            ack;
  logic            pop;
  logic            tmo_hit;
  logic            flush;

  // ------------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------------
  assign full_o  = (count_q == DEPTH_C);
  assign push_ok = wr_cmd_i && !full_o && (state_q != S_ERR);
  assign ack     = resp_rdy_i && (resp_i == ACK_VAL);
  assign pop     = (state_q == S_WAIT_RESP) && ack;
  // The counter starts at 0 on the first wait cycle, so hitting the last
  // value means TIMEOUT_CYCLES cycles have been spent waiting.
  assign tmo_hit = (tmo_q >= TMO_LAST);
  // Queue is discarded on the cycle that enters the error state.
  assign flush   = (state_d == S_ERR) && (state_q != S_ERR);

  // ------------------------------------------------------------------------
  // FIFO occupancy and pointers
  // ------------------------------------------------------------------------

  // Occupancy after this cycle's push/pop, before any flush.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    count_upd = count_q;
    case ({push_ok, pop})
      2'b10:   count_upd = count_q + CW'(1);
      2'b01:   count_upd = count_q - CW'(1);
      default: count_upd = count_q;
    endcase
  end

  assign rd_ptr_pop = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

  // Next pointer/count values; pointers wrap naturally as DEPTH is 2**AW.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_pop;
    count_d  = count_upd;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Script payload storage, written on every accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is not reset; which slots hold live entries is
    // decided entirely by the pointers and count, which are reset.
    if (push_ok) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  assign count_o = count_q;

  // Head entry for the next SEND. If the queue drains to zero on an ACK
  // while a push lands in the same cycle, the new head is still on
  // wr_data_i rather than in the array, so forward it.
  assign head_d = (push_ok && (wr_ptr_q == rd_ptr_pop)) ? wr_data_i
                                                       : mem[rd_ptr_pop];

  // ------------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including the sticky error flag/code and retry count.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    err_code_d = err_code_q;
`ifdef RCOM_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i && (count_q != '0)) begin
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        state_d = S_WAIT_SNT;
      end

      S_WAIT_SNT: begin
        if (cmd_snt_i) begin
          state_d = S_WAIT_RESP;
        end else if (tmo_hit) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_SNT_TMO;
        end
      end

      S_WAIT_RESP: begin
        // A response arriving on the timeout cycle wins over the timeout.
        if (ack) begin
          state_d = (count_upd == '0) ? S_IDLE : S_SEND;
`ifdef RCOM_RETRY_EN
          retry_d = '0;
`endif
        end else if (resp_rdy_i || tmo_hit) begin
`ifdef RCOM_RETRY_EN
          if (retry_q != 2'd3) begin
            state_d = S_SEND;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = resp_rdy_i ? ERR_NAK : ERR_RESP_TMO;
          end
`else
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = resp_rdy_i ? ERR_NAK : ERR_RESP_TMO;
`endif
        end
      end

      S_ERR: begin
`ifdef RCOM_RETRY_EN
        retry_d = '0;
`endif
        if (start_i) begin
          state_d    = S_IDLE;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore/Mealy outputs; done marks the final-ACK transition into IDLE.
  always_comb begin
    snd_cmd_o = (state_q == S_SEND);
    busy_o    = (state_q != S_IDLE) && (state_q != S_ERR);
    done_o    = (state_q == S_WAIT_RESP) && (state_d == S_IDLE);
  end

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------

  // Command register loads on entry to SEND so it is valid alongside the
  // snd_cmd strobe and then holds until the next SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else if (state_d == S_SEND) begin
      cmd_q <= head_d;
    end
  end

  // Wait-state timeout counter: cleared by SEND and by cmd_snt, saturating.
  always_comb begin
    tmo_d = tmo_q;
    if ((state_q == S_SEND) || ((state_q == S_WAIT_SNT) && cmd_snt_i)) begin
      tmo_d = '0;
    end else if (((state_q == S_WAIT_SNT) || (state_q == S_WAIT_RESP)) &&
                 (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Timeout counter and error status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

`ifdef RCOM_RETRY_EN
  // Consecutive-failure count for the current head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign cmd_o      = cmd_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

  // ------------------------------------------------------------------------
  // Structural invariants
  // ------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);

  a_snd_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    snd_cmd_o |=> !snd_cmd_o);

endmodule

// File: doc/rcom_cmd_sequencer.md
Name: rcom_cmd_sequencer

Overview:
- Buffers a script of 16-bit Knight commands and issues them one at a time to the RemoteComm transmitter.
- Issues a command, waits for the transmitter's sent indication, then waits for the Knight's 8-bit response before issuing the next.
- Sits between the host/test script and RemoteComm; replaces hand-driven cmd/snd_cmd sequencing in system-level benches and demo tops.
- Detects NAK and timeout conditions and reports them.

Parameters:
- DEPTH, 8, number of 16-bit command slots in the script FIFO (power of 2, >=2).
- TIMEOUT_CYCLES, 1000000, maximum clk cycles to wait in either wait state before flagging timeout.
- ACK_VAL, 8'hA5, response byte treated as positive acknowledge.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_cmd  in  1  push wr_data into FIFO (ignored when full).
- wr_data  in  16  command to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH+1)  entries currently queued.
- start  in  1  begin executing queued script / clear error.
- cmd  out  16  command presented to RemoteComm.
- snd_cmd  out  1  one-cycle send strobe to RemoteComm.
- cmd_snt  in  1  RemoteComm finished transmitting cmd.
- resp_rdy  in  1  response byte valid (single-cycle pulse).
- resp  in  8  response byte.
- busy  out  1  high in any state other than IDLE and ERR.
- done  out  1  one-cycle pulse when the script completes with all entries ACKed.
- err  out  1  sticky error flag.
- err_code  out  2  2'b01 NAK, 2'b10 cmd_snt timeout, 2'b11 resp timeout.

Behaviour:
- Interface: one clock, clk. Asynchronous active-low reset, rst_n. All flops reset asynchronously.
- Reset values:
  - All outputs 0.
  - FIFO empty; count=0.
  - State IDLE.
  - Timeout counter 0.
- Reset asserted mid-operation aborts immediately; the queued script is discarded.
- FIFO:
  - Circular buffer with rd/wr pointers that wrap modulo DEPTH.
  - wr_cmd accepted in any state except ERR when !full.
  - A push and a pop in the same cycle leave count unchanged.
  - A push while full is dropped silently.
- States: IDLE, SEND, WAIT_SNT, WAIT_RESP, ERR.
- IDLE:
  - start && count>0 -> SEND.
  - start with count==0 -> stays IDLE, no done pulse.
- SEND:
  - cmd <= FIFO head; snd_cmd=1 for exactly this one cycle; clear timeout counter.
  - -> WAIT_SNT.
  - cmd holds its value until the next SEND.
- WAIT_SNT:
  - cmd_snt -> WAIT_RESP, clear timeout counter.
  - Counter reaching TIMEOUT_CYCLES -> ERR, err_code=2'b10.
- WAIT_RESP:
  - resp_rdy && resp==ACK_VAL -> pop head; if count becomes 0 -> IDLE with done pulsed on the transition cycle; else -> SEND.
  - resp_rdy && resp!=ACK_VAL -> ERR, err_code=2'b01, no pop.
  - Timeout -> ERR, err_code=2'b11.
  - A resp_rdy arriving in the same cycle the counter hits TIMEOUT_CYCLES: resp_rdy takes priority.
- Entries pushed while busy join the running script.
- Latency: start to snd_cmd = 1 cycle. ACK to next snd_cmd = 1 cycle (SEND immediately follows).
- ERR:
  - On entry, err=1 and the FIFO is flushed (count=0).
  - busy=0; wr_cmd ignored.
  - start -> clears err and err_code, -> IDLE.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1); saturates and never wraps.
- cmd_snt or resp_rdy outside its wait state is ignored.

Optional Feature:
- Macro: RCOM_RETRY_EN.
- With the macro defined:
  - A NAK or resp timeout re-enters SEND with the same head entry, up to 3 retries per command.
  - The retry counter clears on each ACK.
  - ERR is entered only on the 4th consecutive failure, with err_code of the last failure.
  - A cmd_snt timeout is never retried.
- Without the macro: the first failure goes directly to ERR, as above.

Test Plan:
- Push 16'h2000, 16'h4001, 16'h6003; start; ACK each with 8'hA5 -> snd_cmd three times with cmd in push order, done pulses once, count=0, err=0.
- Single command; respond 8'h5A -> err=1, err_code=2'b01, count=0, busy=0; start -> err=0, IDLE.
- Withhold cmd_snt with TIMEOUT_CYCLES=50 -> err_code=2'b10 after 50 cycles in WAIT_SNT; withhold resp -> err_code=2'b11.
- Push DEPTH+2 entries -> full=1, count=DEPTH, extra entries dropped. Run the script -> exactly DEPTH sends, pointers wrap correctly. Push during a run -> extra entry executed before done.
- Assert rst_n low during WAIT_RESP -> cmd=0, snd_cmd=0, count=0, busy=0 asynchronously; subsequent start with empty FIFO -> no activity.
- With RCOM_RETRY_EN: NAK, NAK, then 8'hA5 -> three snd_cmd with the same cmd, done=1, err=0. Four NAKs -> err_code=2'b01.
